ringer_alert_ctrl: RTL
======================

// Module: ringer_alert_ctrl
//
// PURPOSE
//   Sequences the phone alert outputs for an incoming call. Drives
//   turn_on_ringer / turn_on_motor in an on/off cadence, honours
//   vibrate_mode, stops on answer, and flags a missed call after
//   MAX_RINGS unanswered bursts. Sits between the call-signalling logic
//   and the ringer/motor drivers, replacing a combinational ring decode.
//
// PARAMETERS
//   ON_CYCLES   4  cycles per alert burst (>=1)
//   OFF_CYCLES  2  silent cycles after each burst (>=1)
//   MAX_RINGS   3  bursts before the call is declared missed (>=1)
//
// PORTS
//   clk             in   1  clock; all state updates on posedge
//   reset           in   1  asynchronous, active-high reset
//   call_in         in   1  incoming call request, sampled in IDLE only
//   answer          in   1  user answered; aborts alert
//   vibrate_mode    in   1  1 = motor instead of ringer (sampled live)
//   turn_on_ringer  out  1  ringer drive
//   turn_on_motor   out  1  vibration motor drive
//   busy            out  1  high in ALERT_ON / ALERT_OFF
//   missed_call     out  1  registered 1-cycle pulse on unanswered timeout
//
// BEHAVIOUR
//   - Reset (any time, incl. mid-alert): state=IDLE, counters=0, all
//     outputs 0 immediately; no missed_call pulse.
//   - States: IDLE, ALERT_ON, ALERT_OFF (enum in ringer_pkg).
//   - IDLE: outputs 0. call_in=1 at posedge -> ALERT_ON, burst/ring cnt=0.
//     answer ignored in IDLE (call_in+answer together still starts alert).
//   - ALERT_ON: turn_on_ringer = ~vibrate_mode, turn_on_motor =
//     vibrate_mode (combinational from state + live input). After
//     ON_CYCLES cycles -> ALERT_OFF, ring_cnt += 1.
//   - ALERT_OFF: both drives 0. After OFF_CYCLES cycles: if
//     ring_cnt == MAX_RINGS -> IDLE and missed_call=1 for the first IDLE
//     cycle; else -> ALERT_ON.
//   - answer=1 in ALERT_ON/ALERT_OFF -> IDLE next cycle, no missed_call;
//     answer wins over a simultaneous timeout or phase change.
//   - call_in while busy ignored (no restart, no queueing).
//   - Latency: first drive cycle is the cycle after call_in sampled.
//     Total alert = MAX_RINGS*(ON_CYCLES+OFF_CYCLES) cycles.
//   - Counter widths $clog2(max+1); no wrap is ever reachable.
//
// CONFIGURATION
//   RINGER_ALERT_CTRL_ESCALATE_EN defined: during the final burst
//   (ring_cnt == MAX_RINGS-1) with vibrate_mode=1, BOTH ringer and motor
//   on. Undefined: final burst identical to earlier bursts.
//
// STRUCTURE
//   - ringer_pkg: state enum typedef, default cadence constants.
//   - Sub-module ringer_cadence_timer: loadable down-counter with
//     'expired' flag, reused for ON and OFF phases.
//   - ring_cnt, FSM, output decode and missed_call register in top.
//
// TESTING (defaults ON=4, OFF=2, MAX=3; call_in pulsed at cycle 0)
//   1. vibrate=0, no answer -> ringer=1 cycles 1-4,7-10,13-16, else 0;
//      motor=0 always; busy cycles 1-18; missed_call=1 only cycle 19.
//   2. vibrate=1, no answer -> motor pattern as case 1, ringer=0
//      (with ESCALATE_EN: ringer also 1 cycles 13-16).
//   3. answer=1 at cycle 8 -> drives 0 and busy=0 from cycle 9;
//      missed_call never asserts.
//   4. vibrate toggled 0->1 at cycle 3 -> ringer 1-2, motor 3-4;
//      call_in re-pulsed at cycle 5 -> no change in cadence.
//   5. reset asserted mid-cycle 10 -> outputs 0 at once; after release,
//      call_in restarts full 18-cycle cadence from ring 0.
//   6. answer at cycle 18 (last OFF cycle) -> IDLE at 19, no missed_call.

Source files
------------

// File: rtl/ringer_pkg.sv
// Shared definitions for the ringer alert controller: FSM state encoding,
// default cadence constants and a small elaboration-time helper.
package ringer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALERT_ON  = 2'd1,
    ST_ALERT_OFF = 2'd2
  } ringer_state_e;

  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_OFF_CYCLES = 2;
  localparam int DEF_MAX_RINGS  = 3;

  // Larger of two integers, used to size the shared phase timer.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/ringer_cadence_timer.sv
// Loadable down-counter shared by the ON and OFF phases. 'expired' is high
// while the count sits at zero, i.e. in the last cycle of a phase when the
// counter was loaded with (phase_length - 1).
module ringer_cadence_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Load a new phase length, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/ringer_alert_ctrl.sv
// Incoming-call alert sequencer: bursts of ringer (or motor in vibrate mode)
// separated by silent gaps, aborted by answer, and a one-cycle missed_call
// pulse after MAX_RINGS unanswered bursts.
// Optional build macro: RINGER_ALERT_CTRL_ESCALATE_EN -- when defined, the
// final burst in vibrate mode drives both ringer and motor.
module ringer_alert_ctrl
  import ringer_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int MAX_RINGS  = DEF_MAX_RINGS
) (
  input  logic clk,
  input  logic reset,
  input  logic call_in,
  input  logic answer,
  input  logic vibrate_mode,
  output logic turn_on_ringer,
  output logic turn_on_motor,
  output logic busy,
  output logic missed_call
);

  localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RINGS + 1);
  localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD  = TW'(OFF_CYCLES - 1);
  localparam logic [RW-1:0] LAST_RING = RW'(MAX_RINGS - 1);
  localparam logic [RW-1:0] ALL_RINGS = RW'(MAX_RINGS);

  ringer_state_e   state_r, state_s;
  logic [RW-1:0]   ring_cnt_r, ring_cnt_s;
  logic            missed_call_r, missed_s;
  logic            timer_load_s;
  logic [TW-1:0]   timer_val_s;
  logic            timer_expired_s;
  logic            escalate_s;

  ringer_cadence_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .expired  (timer_expired_s)
  );

`ifdef RINGER_ALERT_CTRL_ESCALATE_EN
  assign escalate_s = vibrate_mode & (ring_cnt_r == LAST_RING);
`else
  assign escalate_s = 1'b0;
`endif

  // State, ring counter and missed-call pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ring_cnt_r    <= {RW{1'b0}};
      missed_call_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      ring_cnt_r    <= ring_cnt_s;
      missed_call_r <= missed_s;
    end
  end

  // Next-state logic; answer takes priority over any phase change or timeout.
  always_comb begin
    state_s      = state_r;
    ring_cnt_s   = ring_cnt_r;
    timer_load_s = 1'b0;
    timer_val_s  = ON_LOAD;
    missed_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (call_in) begin
          state_s      = ST_ALERT_ON;
          ring_cnt_s   = {RW{1'b0}};
          timer_load_s = 1'b1;
          timer_val_s  = ON_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ALERT_ON: begin
        if (answer) begin
          state_s = ST_IDLE;
        end else if (timer_expired_s) begin
          state_s      = ST_ALERT_OFF;
          ring_cnt_s   = ring_cnt_r + RW'(1);
          timer_load_s = 1'b1;
          timer_val_s  = OFF_LOAD;
        end else begin
          state_s = ST_ALERT_ON;
        end
      end
      ST_ALERT_OFF: begin
        if (answer) begin
          state_s = ST_IDLE;
        end else if (timer_expired_s) begin
          if (ring_cnt_r == ALL_RINGS) begin
            state_s  = ST_IDLE;
            missed_s = 1'b1;
          end else begin
            state_s      = ST_ALERT_ON;
            timer_load_s = 1'b1;
            timer_val_s  = ON_LOAD;
          end
        end else begin
          state_s = ST_ALERT_OFF;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from current state and the live vibrate_mode input.
  always_comb begin
    turn_on_ringer = 1'b0;
    turn_on_motor  = 1'b0;
    busy           = 1'b0;
    case (state_r)
      ST_ALERT_ON: begin
        turn_on_ringer = ~vibrate_mode | escalate_s;
        turn_on_motor  = vibrate_mode;
        busy           = 1'b1;
      end
      ST_ALERT_OFF: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign missed_call = missed_call_r;

endmodule
